// File: rtl/alu_issue_if.sv
// Bundle of the issue-stage handshake, ALU drive/return and writeback signals.
// master: instruction producer / ALU / debug side. slave: the issue stage.
interface alu_issue_if #(
    parameter int REG_AW = 3,
    parameter int DW     = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [15:0]       alu_imm;
    logic [4:0]        alu_shift;
    logic [5:0]        alu_ctrl;
    logic [5:0]        alu_y;
    logic [5:0]        alu_y1;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [DW-1:0]     wb_data;
    logic              err_illegal;
    logic              err_div0;
    logic              ovf;
    logic [REG_AW-1:0] dbg_addr;
    logic [DW-1:0]     dbg_data;

    modport master (
        output in_valid, in_instr, alu_y, alu_y1, dbg_addr,
        input  in_ready, alu_a, alu_b, alu_imm, alu_shift, alu_ctrl,
               wb_valid, wb_addr, wb_data, err_illegal, err_div0, ovf, dbg_data
    );

    modport slave (
        input  in_valid, in_instr, alu_y, alu_y1, dbg_addr,
        output in_ready, alu_a, alu_b, alu_imm, alu_shift, alu_ctrl,
               wb_valid, wb_addr, wb_data, err_illegal, err_div0, ovf, dbg_data
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue stage for the 6-opcode ALU: decodes one instruction word,
// drives registered operands to the ALU, then writes the ALU result back
// into the local register file on the following edge.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for an instruction; decode and register ALU operands
// EXEC  | ALU settles on registered operands; result written at edge
module alu_issue_stage #(
    parameter int REG_AW = 3,
    parameter int DW     = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_issue_if.slave bus
);
    localparam int NREG = 2 ** REG_AW;

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DW-1:0]     regs [NREG];

    logic [5:0]        ctrl;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic              is_rtype;
    logic              is_itype;
    logic              legal;
    logic [DW-1:0]     rs_val;
    logic [DW-1:0]     rt_val;

    logic              accept;
    logic              issue;
    logic              illegal;
    logic [5:0]        result;

    logic [REG_AW-1:0] rd_q;
    logic              itype_q;
    logic              div0_q;

    assign ctrl     = bus.in_instr[31:26];
    assign rd       = bus.in_instr[23 +: REG_AW];
    assign rs       = bus.in_instr[20 +: REG_AW];
    assign rt       = bus.in_instr[17 +: REG_AW];
    assign shamt    = bus.in_instr[16:12];
    assign imm      = bus.in_instr[15:0];

    assign is_rtype = (ctrl <= 6'd6);
    assign is_itype = (ctrl == 6'd10) || (ctrl == 6'd11);
    assign legal    = is_rtype || is_itype;

    // r0 is never written and resets to zero, so plain array reads give r0 = 0
    assign rs_val       = regs[rs];
    assign rt_val       = regs[rt];
    assign bus.dbg_data = regs[bus.dbg_addr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE -> EXEC only on a legal accepted instruction
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs and handshake qualifiers derived from the current state
    always_comb begin
        bus.in_ready = (state == S_IDLE);
        accept       = bus.in_ready && bus.in_valid;
        issue        = accept && legal;
        illegal      = accept && !legal;
        result       = itype_q ? bus.alu_y1 : bus.alu_y;
    end

    // Issue registers: ALU operands and the decode carried into EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_imm     <= '0;
            bus.alu_shift   <= '0;
            bus.alu_ctrl    <= '0;
            bus.err_illegal <= 1'b0;
            rd_q            <= '0;
            itype_q         <= 1'b0;
            div0_q          <= 1'b0;
        end else begin
            bus.err_illegal <= illegal;
            if (issue) begin
                bus.alu_a    <= rs_val;
                bus.alu_ctrl <= ctrl;
                rd_q         <= rd;
                itype_q      <= is_itype;
                // divide-by-zero is judged on the operand read at issue
                div0_q       <= (ctrl == 6'd4) && (rt_val == '0);
                if (is_itype) begin
                    bus.alu_b     <= '0;
                    bus.alu_imm   <= imm;
                    bus.alu_shift <= '0;
                end else begin
                    bus.alu_b     <= rt_val;
                    bus.alu_imm   <= '0;
                    bus.alu_shift <= shamt;
                end
            end
        end
    end

    // Writeback: register file update, result pulses and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            bus.wb_valid <= 1'b0;
            bus.wb_addr  <= '0;
            bus.wb_data  <= '0;
            bus.err_div0 <= 1'b0;
            bus.ovf      <= 1'b0;
        end else begin
            bus.wb_valid <= 1'b0;
            bus.err_div0 <= 1'b0;
            if (state == S_EXEC) begin
                if (div0_q) begin
                    bus.err_div0 <= 1'b1;
                end else begin
                    bus.wb_valid <= 1'b1;
                    bus.wb_addr  <= rd_q;
                    bus.wb_data  <= result[DW-1:0];
                    if (rd_q != '0) begin
                        regs[rd_q] <= result[DW-1:0];
                    end
                    // bit 5 is lost on writeback; remember that it happened
                    if (result[5]) begin
                        bus.ovf <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU drives Y/Y1 from the stage's
// operands; a register-array reference model predicts every writeback.
module tb_alu_issue_stage;
    localparam int REG_AW = 3;
    localparam int DW     = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] ref_regs [8];
    logic          ref_ovf;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic [15:0]   exp_imm;
    logic [4:0]    exp_sh;
    logic [5:0]    exp_ctrl;
    logic [31:0]   rnd_w;
    int            rnd_sel;

    alu_issue_if #(.REG_AW(REG_AW), .DW(DW)) bus ();

    alu_issue_stage #(.REG_AW(REG_AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] alu_r(input logic [5:0] c, input logic [4:0] a,
                                         input logic [4:0] b, input logic [4:0] sh);
        logic [5:0] a6;
        logic [5:0] b6;
        a6 = {1'b0, a};
        b6 = {1'b0, b};
        case (c)
            6'd0:    return a6 & b6;
            6'd1:    return a6 | b6;
            6'd2:    return {1'b0, ~a};
            6'd3:    return a6 * b6;
            6'd4:    return (b == 5'd0) ? 6'h3F : a6 / b6;
            6'd5:    return a6 >> sh;
            6'd6:    return a6 << sh;
            default: return 6'h15;
        endcase
    endfunction

    function automatic logic [5:0] alu_i(input logic [5:0] c, input logic [4:0] a,
                                         input logic [15:0] imm);
        logic [15:0] s;
        case (c)
            6'd10:   s = {11'd0, a} + imm;
            6'd11:   s = {11'd0, a} - imm;
            default: s = 16'h002A;
        endcase
        return s[5:0];
    endfunction

    // behavioural ALU: Y answers only R-type ops, Y1 only I-type ops
    always_comb begin
        bus.alu_y  = alu_r(bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.alu_shift);
        bus.alu_y1 = alu_i(bus.alu_ctrl, bus.alu_a, bus.alu_imm);
    end

    function automatic logic [31:0] enc_r(input int c, input int rd, input int rs,
                                          input int rt, input int sh);
        return {6'(c), 3'(rd), 3'(rs), 3'(rt), 5'(sh), 12'h000};
    endfunction

    function automatic logic [31:0] enc_i(input int c, input int rd, input int rs,
                                          input int imm);
        return {6'(c), 3'(rd), 3'(rs), 4'h0, 16'(imm)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [2:0] a);
        bus.dbg_addr = a;
        #1;
        chk("dbg_reg", 32'(bus.dbg_data), 32'(ref_regs[a]));
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) ref_regs[i] = '0;
        ref_ovf  = 1'b0;
        exp_a    = '0;
        exp_b    = '0;
        exp_imm  = '0;
        exp_sh   = '0;
        exp_ctrl = '0;
    endtask

    // one instruction through handshake, operand drive and writeback
    task automatic do_instr(input logic [31:0] ins);
        logic [5:0] c;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       is_r;
        logic       is_i;
        logic       div0;
        logic [5:0] res;
        c    = ins[31:26];
        rd   = ins[25:23];
        rs   = ins[22:20];
        rt   = ins[19:17];
        is_r = (c < 6'd7);
        is_i = (c == 6'd10) || (c == 6'd11);
        @(negedge clk);
        chk("ready_before", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_instr = $urandom;
        @(negedge clk);
        if (!(is_r || is_i)) begin
            chk("illegal_pulse", 32'(bus.err_illegal), 32'd1);
            chk("illegal_ready", 32'(bus.in_ready), 32'd1);
            chk("illegal_nowb", 32'(bus.wb_valid), 32'd0);
            chk("illegal_ctrl_hold", 32'(bus.alu_ctrl), 32'(exp_ctrl));
            chk("illegal_a_hold", 32'(bus.alu_a), 32'(exp_a));
            chk("illegal_imm_hold", 32'(bus.alu_imm), 32'(exp_imm));
            @(negedge clk);
            chk("illegal_pulse_end", 32'(bus.err_illegal), 32'd0);
            chk("illegal_nowb2", 32'(bus.wb_valid), 32'd0);
        end else begin
            exp_a    = ref_regs[rs];
            exp_ctrl = c;
            exp_b    = is_r ? ref_regs[rt] : '0;
            exp_sh   = is_r ? ins[16:12] : '0;
            exp_imm  = is_i ? ins[15:0] : '0;
            chk("alu_a", 32'(bus.alu_a), 32'(exp_a));
            chk("alu_b", 32'(bus.alu_b), 32'(exp_b));
            chk("alu_imm", 32'(bus.alu_imm), 32'(exp_imm));
            chk("alu_shift", 32'(bus.alu_shift), 32'(exp_sh));
            chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(exp_ctrl));
            chk("exec_ready", 32'(bus.in_ready), 32'd0);
            res  = is_r ? alu_r(c, exp_a, exp_b, exp_sh) : alu_i(c, exp_a, exp_imm);
            div0 = (c == 6'd4) && (exp_b == '0);
            @(negedge clk);
            chk("wb_ready", 32'(bus.in_ready), 32'd1);
            if (div0) begin
                chk("div0_pulse", 32'(bus.err_div0), 32'd1);
                chk("div0_nowb", 32'(bus.wb_valid), 32'd0);
            end else begin
                chk("wb_valid", 32'(bus.wb_valid), 32'd1);
                chk("wb_addr", 32'(bus.wb_addr), 32'(rd));
                chk("wb_data", 32'(bus.wb_data), 32'(res[4:0]));
                chk("no_div0", 32'(bus.err_div0), 32'd0);
                if (rd != 3'd0) ref_regs[rd] = res[4:0];
                if (res[5]) ref_ovf = 1'b1;
            end
            chk("ovf", 32'(bus.ovf), 32'(ref_ovf));
            chk_reg(rd);
            @(negedge clk);
            chk("wb_pulse_end", 32'(bus.wb_valid), 32'd0);
            chk("div0_pulse_end", 32'(bus.err_div0), 32'd0);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.dbg_addr = '0;
        reset_model();

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        chk("rst_alu_imm", 32'(bus.alu_imm), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_err_illegal", 32'(bus.err_illegal), 32'd0);
        chk("rst_err_div0", 32'(bus.err_div0), 32'd0);

        // ADDI r1,r0,#7 ; ADDI r2,r0,#3 ; MUL r3,r1,r2 ; SHL r4,r2,4 (overflow)
        do_instr(enc_i(10, 1, 0, 7));
        do_instr(enc_i(10, 2, 0, 3));
        do_instr(enc_r(3, 3, 1, 2, 0));
        chk("mul_r3", 32'(ref_regs[3]), 32'd21);
        do_instr(enc_r(6, 4, 2, 0, 4));
        chk("shl_ovf", 32'(bus.ovf), 32'd1);

        // DIV r5,r1,r0 -> divide by zero, r5 stays 0
        do_instr(enc_r(4, 5, 1, 0, 0));
        chk_reg(3'd5);

        // ctrl=7 is illegal
        do_instr({6'd7, 26'h2AB_CDEF});

        // back-to-back with in_valid held: ADDI r1,r0,#5 then SUBI r2,r1,#2
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = enc_i(10, 1, 0, 5);
        chk("b2b_ready0", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("b2b_ready1", 32'(bus.in_ready), 32'd0);
        chk("b2b_imm1", 32'(bus.alu_imm), 32'd5);
        bus.in_instr = enc_i(11, 2, 1, 2);
        @(negedge clk);
        chk("b2b_ready2", 32'(bus.in_ready), 32'd1);
        chk("b2b_wb1_valid", 32'(bus.wb_valid), 32'd1);
        chk("b2b_wb1_data", 32'(bus.wb_data), 32'd5);
        @(negedge clk);
        chk("b2b_ready3", 32'(bus.in_ready), 32'd0);
        chk("b2b_alu_a2", 32'(bus.alu_a), 32'd5);
        chk("b2b_ctrl2", 32'(bus.alu_ctrl), 32'd11);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_wb2_valid", 32'(bus.wb_valid), 32'd1);
        chk("b2b_wb2_addr", 32'(bus.wb_addr), 32'd2);
        chk("b2b_wb2_data", 32'(bus.wb_data), 32'd3);
        ref_regs[1] = 5'd5;
        ref_regs[2] = 5'd3;
        exp_a    = 5'd5;
        exp_b    = '0;
        exp_imm  = 16'd2;
        exp_sh   = '0;
        exp_ctrl = 6'd11;
        chk_reg(3'd2);

        // randomized instruction mix against the reference model
        for (int n = 0; n < 60; n++) begin
            rnd_sel = $urandom_range(0, 10);
            rnd_w   = $urandom;
            if (rnd_sel < 7)       rnd_w[31:26] = 6'(rnd_sel);
            else if (rnd_sel == 7) rnd_w[31:26] = 6'd10;
            else if (rnd_sel == 8) rnd_w[31:26] = 6'd11;
            else if (rnd_sel == 9) rnd_w[31:26] = 6'($urandom_range(7, 9));
            else                   rnd_w[31:26] = 6'($urandom_range(12, 63));
            do_instr(rnd_w);
        end

        // reset during EXEC of ADDI r6,r0,#9 aborts the write
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_instr = enc_i(10, 6, 0, 9);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("abort_exec", 32'(bus.in_ready), 32'd0);
        chk("abort_imm", 32'(bus.alu_imm), 32'd9);
        rst_n = 1'b0;
        #1;
        chk("abort_imm_rst", 32'(bus.alu_imm), 32'd0);
        @(negedge clk);
        chk("abort_nowb", 32'(bus.wb_valid), 32'd0);
        rst_n = 1'b1;
        reset_model();
        @(negedge clk);
        chk("abort_nowb2", 32'(bus.wb_valid), 32'd0);
        chk("abort_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        chk_reg(3'd6);
        chk_reg(3'd1);

        // normal operation resumes
        do_instr(enc_i(10, 6, 0, 9));
        do_instr(enc_r(2, 7, 6, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
